mat_result_streamer: RTL and testbench

//   Read-side companion of mat_mul: captures mat_mul's parallel N x N result once its

---
 rtl/mat_result_streamer_if.sv | 16 +
 rtl/mat_result_streamer.sv | 138 +++++++++++++
 tb/tb_mat_result_streamer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mat_result_streamer_if.sv
// Element stream leaving mat_result_streamer: one matrix element per valid/ready transfer,
// tagged with its row/column and a last marker for element [N-1][N-1].
interface mat_result_streamer_if #(
  parameter int W_OUT = 32,
  parameter int N     = 4
);
  logic [W_OUT-1:0]     m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [$clog2(N)-1:0] m_row;
  logic [$clog2(N)-1:0] m_col;
  logic                 m_last;

  modport master (output m_data, m_valid, m_row, m_col, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_row, m_col, m_last, output m_ready);
endinterface

// File: rtl/mat_result_streamer.sv
// Captures mat_mul's parallel N x N result LATENCY cen-qualified edges after launch and
// streams it out row-major, one element per valid/ready transfer.
module mat_result_streamer #(
  parameter int W_OUT   = 32,
  parameter int N       = 4,
  parameter int LATENCY = $clog2(N) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cen,
  input  logic                             launch,
  input  logic [N-1:0][N-1:0][W_OUT-1:0]   result,
  mat_result_streamer_if.master            m,
  output logic                             busy,
  output logic                             overrun
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [RW-1:0] IDX_MAX  = RW'(N - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [1:0]                       state_r;
  logic [CW-1:0]                    count_r;
  logic [N-1:0][N-1:0][W_OUT-1:0]   buf_r;
  logic [RW-1:0]                    row_r;
  logic [RW-1:0]                    col_r;
  logic [W_OUT-1:0]                 data_r;
  logic                             valid_r;
  logic                             last_r;
  logic                             busy_r;
  logic                             overrun_r;

  logic                             xfer_s;
  logic                             final_s;
  logic                             relaunch_s;
  logic [RW-1:0]                    nxt_row_s;
  logic [RW-1:0]                    nxt_col_s;
  logic                             nxt_last_s;

  // Handshake decode and row-major successor of the element currently presented
  always_comb begin
    xfer_s     = valid_r & m.m_ready;
    final_s    = xfer_s & last_r;
    relaunch_s = final_s & launch & cen;
    if (col_r == IDX_MAX) begin
      nxt_row_s = row_r + 1'b1;
      nxt_col_s = '0;
    end else begin
      nxt_row_s = row_r;
      nxt_col_s = col_r + 1'b1;
    end
    nxt_last_s = (nxt_row_s == IDX_MAX) && (nxt_col_s == IDX_MAX);
  end

  // IDLE/WAIT/STREAM sequencer; cen only paces the wait, the stream follows the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      buf_r     <= '0;
      row_r     <= '0;
      col_r     <= '0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch && cen) begin
            state_r <= ST_WAIT;
            count_r <= CNT_INIT;
            busy_r  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (launch) begin
            overrun_r <= 1'b1;
          end
          if (cen) begin
            if (count_r == '0) begin
              state_r <= ST_STREAM;
              buf_r   <= result;
              row_r   <= '0;
              col_r   <= '0;
              data_r  <= result[0][0];
              last_r  <= (IDX_MAX == '0);
              valid_r <= 1'b1;
            end else begin
              count_r <= count_r - 1'b1;
            end
          end
        end
        ST_STREAM: begin
          // A launch coinciding with the final transfer chains straight into the next wait
          if (launch && !relaunch_s) begin
            overrun_r <= 1'b1;
          end
          if (final_s) begin
            valid_r <= 1'b0;
            if (relaunch_s) begin
              state_r <= ST_WAIT;
              count_r <= CNT_INIT;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else if (xfer_s) begin
            row_r  <= nxt_row_s;
            col_r  <= nxt_col_s;
            data_r <= buf_r[nxt_row_s][nxt_col_s];
            last_r <= nxt_last_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign m.m_data  = data_r;
  assign m.m_valid = valid_r;
  assign m.m_row   = row_r;
  assign m.m_col   = col_r;
  assign m.m_last  = last_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer (N=4, W_OUT=32, default LATENCY=3) with
// hand-computed expected element streams.
module tb_mat_result_streamer;
  localparam int W = 32;
  localparam int N = 4;
  localparam int F_ALT   = 1;
  localparam int F_MUT   = 2;
  localparam int F_L5    = 4;
  localparam int F_LLAST = 8;
  localparam int F_RST5  = 16;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic launch;
  logic [N-1:0][N-1:0][W-1:0] result;
  logic busy;
  logic overrun;
  logic [W-1:0] exp_m [16];
  int checks = 0;
  int errors = 0;

  mat_result_streamer_if #(.W_OUT(W), .N(N)) mif();

  mat_result_streamer #(.W_OUT(W), .N(N)) dut (
    .clk(clk), .rst(rst), .cen(cen), .launch(launch), .result(result),
    .m(mif), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_res(input int base);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        result[i][j] = 32'(base + i * 4 + j);
  endtask

  task automatic set_exp(input int base);
    for (int k = 0; k < 16; k++)
      exp_m[k] = 32'(base + k);
  endtask

  // Launch at edge E; the first valid element appears after E+3 (+2 when cen stalls twice)
  task automatic launch_and_wait(input bit stall);
    launch = 1'b1;
    tick();
    launch = 1'b0;
    check_eq("busy_after_launch", 64'(busy), 64'd1);
    check_eq("valid_in_wait", 64'(mif.m_valid), 64'd0);
    if (stall) begin
      cen = 1'b0;
      tick();
      tick();
      cen = 1'b1;
      check_eq("valid_during_stall", 64'(mif.m_valid), 64'd0);
    end
    tick();
    tick();
    check_eq("valid_before_capture", 64'(mif.m_valid), 64'd0);
    tick();
    check_eq("valid_after_capture", 64'(mif.m_valid), 64'd1);
  endtask

  task automatic run_stream(input int flags);
    int k = 0;
    bit v;
    bit stop = 1'b0;
    bit l5_done = 1'b0;
    for (int cyc = 0; cyc < 200 && k < 16 && !stop; cyc++) begin
      mif.m_ready = ((flags & F_ALT) != 0) ? ((cyc % 2) == 0) : 1'b1;
      v = mif.m_valid;
      if (v) begin
        check_eq("elem_data", 64'(mif.m_data), 64'(exp_m[k]));
        check_eq("elem_row", 64'(mif.m_row), 64'(k / 4));
        check_eq("elem_col", 64'(mif.m_col), 64'(k % 4));
        check_eq("elem_last", 64'(mif.m_last), 64'(k == 15));
        if ((flags & F_L5) != 0 && k == 5 && !l5_done) begin
          launch  = 1'b1;
          l5_done = 1'b1;
        end
        if ((flags & F_LLAST) != 0 && k == 15) launch = 1'b1;
        if ((flags & F_RST5) != 0 && k == 5) begin
          rst  = 1'b1;
          stop = 1'b1;
        end
        if ((flags & F_MUT) != 0 && k == 1) set_res(32'h5A00);
      end
      tick();
      launch = 1'b0;
      rst    = 1'b0;
      if (v && mif.m_ready && !stop) k++;
    end
    if (!stop) check_eq("xfer_count", 64'(k), 64'd16);
  endtask

  initial begin
    rst = 1'b1;
    cen = 1'b0;
    launch = 1'b0;
    mif.m_ready = 1'b0;
    result = '0;

    // 1: reset with random inputs
    for (int c = 0; c < 2; c++) begin
      cen = 1'($urandom_range(0, 1));
      launch = 1'($urandom_range(0, 1));
      mif.m_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          result[i][j] = $urandom;
      tick();
    end
    check_eq("rst_valid", 64'(mif.m_valid), 64'd0);
    check_eq("rst_data", 64'(mif.m_data), 64'd0);
    check_eq("rst_row", 64'(mif.m_row), 64'd0);
    check_eq("rst_col", 64'(mif.m_col), 64'd0);
    check_eq("rst_last", 64'(mif.m_last), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    launch = 1'b0;
    cen = 1'b1;
    mif.m_ready = 1'b1;
    tick();

    // 2: full-rate stream of 0..15
    set_res(0);
    set_exp(0);
    launch_and_wait(1'b0);
    run_stream(0);
    check_eq("t2_valid_end", 64'(mif.m_valid), 64'd0);
    check_eq("t2_busy_end", 64'(busy), 64'd0);

    // 3: alternating ready, result scribbled during the stream
    set_res(0);
    launch_and_wait(1'b0);
    run_stream(F_ALT | F_MUT);
    check_eq("t3_busy_end", 64'(busy), 64'd0);

    // 4: two stalled cen cycles during the wait
    set_res(16);
    set_exp(16);
    launch_and_wait(1'b1);
    run_stream(0);

    // 5a: launch on the final transfer chains a second matrix without overrun
    set_res(100);
    set_exp(100);
    launch_and_wait(1'b0);
    set_res(200);
    run_stream(F_LLAST);
    check_eq("t5a_valid_gap", 64'(mif.m_valid), 64'd0);
    check_eq("t5a_busy_chain", 64'(busy), 64'd1);
    check_eq("t5a_no_overrun", 64'(overrun), 64'd0);
    set_exp(200);
    tick();
    tick();
    check_eq("t5a_valid_before_capture", 64'(mif.m_valid), 64'd0);
    tick();
    check_eq("t5a_valid_after_capture", 64'(mif.m_valid), 64'd1);
    run_stream(0);
    check_eq("t5a_overrun_end", 64'(overrun), 64'd0);
    check_eq("t5a_busy_end", 64'(busy), 64'd0);

    // 5b: launch mid-stream is dropped and flagged
    set_res(300);
    set_exp(300);
    launch_and_wait(1'b0);
    run_stream(F_L5);
    check_eq("t5b_overrun", 64'(overrun), 64'd1);
    check_eq("t5b_busy_end", 64'(busy), 64'd0);

    // 6: reset mid-stream, then a signed element streams bit-exact
    launch_and_wait(1'b0);
    run_stream(F_RST5);
    check_eq("t6_valid_after_rst", 64'(mif.m_valid), 64'd0);
    check_eq("t6_busy_after_rst", 64'(busy), 64'd0);
    check_eq("t6_overrun_after_rst", 64'(overrun), 64'd0);
    tick();
    check_eq("t6_valid_stays_low", 64'(mif.m_valid), 64'd0);
    set_res(0);
    result[0][0] = 32'hFFFF_FFF9;
    set_exp(0);
    exp_m[0] = 32'hFFFF_FFF9;
    launch_and_wait(1'b0);
    run_stream(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
